// File: rtl/branch_predictor_ctrl.sv
// rtl/branch_predictor_ctrl.sv - direct-mapped branch target buffer with 2-bit counters and mispredict flush
// Optional statistics counters: define BP_STATS_EN.
module branch_predictor_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ENTRIES = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_pc,
  output logic              predict_taken,
  output logic [DATA_W-1:0] predict_pc,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic              ex_predicted,
  input  logic [DATA_W-1:0] ex_target,
  input  logic [DATA_W-1:0] ex_redirect_pc,
  output logic              flush,
  output logic [DATA_W-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [15:0]       stat_branches,
  output logic [15:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [DATA_W-1:0]  target_q [ENTRIES];
  logic [DATA_W-1:0]  target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic               flush_q, flush_d;
  logic [DATA_W-1:0]  redirect_q, redirect_d;

  logic [IDX_W-1:0]   if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic               if_hit, ex_hit, mispredict;

  // Word-aligned PCs: the two low bits never select or tag an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[DATA_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[DATA_W-1:IDX_W+2];

  // Zero-latency lookup from registered table; reset forces a miss.
  always_comb begin
    if_hit        = if_valid & arst_n & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
    predict_taken = if_hit & ctr_q[if_idx][1];
    predict_pc    = if_hit ? target_q[if_idx] : '0;
  end

  // Table update on branch resolution and mispredict detection.
  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    target_d   = target_q;
    ctr_d      = ctr_q;
    ex_hit     = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
    mispredict = ex_valid & (ex_taken != ex_predicted);
    flush_d    = mispredict;
    redirect_d = mispredict ? ex_redirect_pc : redirect_q;
    if (ex_valid) begin
      if (ex_hit) begin
        if (ex_taken) begin
          target_d[ex_idx] = ex_target;
          if (ctr_q[ex_idx] != 2'd3) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
        end else if (ctr_q[ex_idx] != 2'd0) begin
          ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = 2'd2;
      end
    end
  end

  // Table and flush state registers.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      valid_q    <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'd1;
      end
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      ctr_q      <= ctr_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  // A pending flush is suppressed as soon as reset is asserted.
  assign flush       = flush_q & arst_n;
  assign redirect_pc = redirect_q;

`ifdef BP_STATS_EN
  logic [15:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  // Saturating event counters.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (ex_valid && stat_br_q != 16'hFFFF) stat_br_d = stat_br_q + 16'd1;
    if (mispredict && stat_mp_q != 16'hFFFF) stat_mp_d = stat_mp_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// tb/tb_branch_predictor_ctrl.sv - directed self-checking bench for branch_predictor_ctrl
module tb_branch_predictor_ctrl;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [15:0] if_pc = '0;
  logic        predict_taken;
  logic [15:0] predict_pc;
  logic        ex_valid = 1'b0;
  logic [15:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic        ex_predicted = 1'b0;
  logic [15:0] ex_target = '0;
  logic [15:0] ex_redirect_pc = '0;
  logic        flush;
  logic [15:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int errors = 0;
  int checks = 0;

  branch_predictor_ctrl #(.DATA_W(16), .ENTRIES(16)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .predict_taken  (predict_taken),
    .predict_pc     (predict_pc),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_predicted   (ex_predicted),
    .ex_target      (ex_target),
    .ex_redirect_pc (ex_redirect_pc),
    .flush          (flush),
    .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [15:0] pc, input logic tk, input logic pr,
                        input logic [15:0] tgt, input logic [15:0] rd);
    ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_predicted = pr;
    ex_target = tgt; ex_redirect_pc = rd;
  endtask

  task automatic clr_ex;
    ex_valid = 1'b0;
  endtask

  task automatic lookup(input logic [15:0] pc);
    if_valid = 1'b1; if_pc = pc;
    #1;
  endtask

  initial begin
    // Reset
    tick; tick;
    lookup(16'h0040);
    check("rst_pt", predict_taken, 0);
    check("rst_flush", flush, 0);
    check("rst_redir", redirect_pc, 0);
`ifdef BP_STATS_EN
    check("rst_stat_br", stat_branches, 0);
    check("rst_stat_mp", stat_mispredicts, 0);
`endif
    arst_n = 1'b1;
    tick;

    // Cold miss
    lookup(16'h0040);
    check("cold_pt", predict_taken, 0);
    check("cold_ppc", predict_pc, 0);

    // Allocate with mispredict; same-cycle lookup sees old contents
    set_ex(16'h0040, 1, 0, 16'h0080, 16'h0080);
    lookup(16'h0040);
    check("same_cyc_pt", predict_taken, 0);
    tick; clr_ex; #1;
    check("alloc_flush", flush, 1);
    check("alloc_redir", redirect_pc, 16'h0080);
    check("alloc_pt", predict_taken, 1);
    check("alloc_ppc", predict_pc, 16'h0080);
    tick;
    check("flush_1cyc", flush, 0);
    check("redir_hold", redirect_pc, 16'h0080);

    // Back-to-back mispredicts, counter 2->1->0
    set_ex(16'h0040, 0, 1, 16'h0080, 16'h0044);
    tick;
    set_ex(16'h0040, 0, 1, 16'h0080, 16'h0048);
    #1;
    check("b2b_flush0", flush, 1);
    check("b2b_redir0", redirect_pc, 16'h0044);
    tick; clr_ex; #1;
    check("b2b_flush1", flush, 1);
    check("b2b_redir1", redirect_pc, 16'h0048);
    check("ctr0_pt", predict_taken, 0);
    check("ctr0_ppc", predict_pc, 16'h0080);
    tick;
    check("b2b_end", flush, 0);

    // Three more not-taken: stays at 0
    for (int i = 0; i < 3; i++) begin
      set_ex(16'h0040, 0, 0, 16'h0080, 16'h0044);
      tick;
    end
    clr_ex; #1;
    check("nt_noflush", flush, 0);
    set_ex(16'h0040, 1, 1, 16'h0080, 16'h0080);
    tick; clr_ex; #1;
    check("sat0_pt", predict_taken, 0);
    set_ex(16'h0040, 1, 1, 16'h0080, 16'h0080);
    tick; clr_ex; #1;
    check("ctr2_pt", predict_taken, 1);

    // Saturate at 3 and overwrite target
    for (int i = 0; i < 3; i++) begin
      set_ex(16'h0040, 1, 1, 16'h0100, 16'h0100);
      tick;
    end
    clr_ex; #1;
    check("tgt_ovr_ppc", predict_pc, 16'h0100);
    for (int i = 0; i < 2; i++) begin
      set_ex(16'h0040, 0, 0, 16'h0100, 16'h0044);
      tick;
    end
    clr_ex; #1;
    check("sat3_pt", predict_taken, 0);

    // Alias replaces entry at index 0
    set_ex(16'h0080, 1, 0, 16'h0200, 16'h0200);
    tick; clr_ex; #1;
    check("alias_flush", flush, 1);
    check("alias_redir", redirect_pc, 16'h0200);
    lookup(16'h0040);
    check("alias_old_pt", predict_taken, 0);
    check("alias_old_ppc", predict_pc, 0);
    lookup(16'h0080);
    check("alias_new_pt", predict_taken, 1);
    check("alias_new_ppc", predict_pc, 16'h0200);

    // Not-taken miss leaves table unchanged
    set_ex(16'h0040, 0, 0, 16'h0999, 16'h0044);
    tick; clr_ex;
    lookup(16'h0080);
    check("ntmiss_pt", predict_taken, 1);
    check("ntmiss_ppc", predict_pc, 16'h0200);
    lookup(16'h0040);
    check("ntmiss_alloc", predict_taken, 0);

    // Mispredict followed by reset; coincident ex_valid overridden
    set_ex(16'h0040, 1, 0, 16'h0300, 16'h0300);
    tick;
    arst_n = 1'b0;
    lookup(16'h0080);
    check("rst_n1_flush", flush, 0);
    check("rst_n1_pt", predict_taken, 0);
    tick; clr_ex; arst_n = 1'b1; #1;
    check("rst_n2_flush", flush, 0);
    check("rst_n2_redir", redirect_pc, 0);
    lookup(16'h0040);
    check("rst_ovr_pt", predict_taken, 0);
    check("rst_ovr_ppc", predict_pc, 0);
    lookup(16'h0080);
    check("rst_clr_pt", predict_taken, 0);

`ifdef BP_STATS_EN
    set_ex(16'h0010, 0, 0, 16'h0000, 16'h0014); tick;
    set_ex(16'h0014, 1, 0, 16'h0400, 16'h0400); tick;
    set_ex(16'h0018, 0, 0, 16'h0000, 16'h001C); tick;
    set_ex(16'h001C, 0, 1, 16'h0000, 16'h0020); tick;
    set_ex(16'h0020, 0, 0, 16'h0000, 16'h0024); tick;
    clr_ex; #1;
    check("stat_br", stat_branches, 5);
    check("stat_mp", stat_mispredicts, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
